// File: rtl/core_bus_unit_if.sv
// Request/response handshake plus the byte-wide synchronous memory port of core_bus_unit.
// "slave" is the bus unit side; "master" is the execution core and memory side.
interface core_bus_unit_if #(
   parameter int ADDR_WIDTH = 20,
   parameter int MAX_BYTES  = 4
);
   localparam int SW = $clog2(MAX_BYTES);

   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [SW-1:0]           req_size;
   logic [15:0]             req_seg;
   logic [15:0]             req_off;
   logic [8*MAX_BYTES-1:0]  req_wdata;
   logic                    rsp_valid;
   logic [8*MAX_BYTES-1:0]  rsp_rdata;
   logic                    busy;
   logic [ADDR_WIDTH-1:0]   address;
   logic [7:0]              data;
   logic [7:0]              out;
   logic                    wren;

   modport slave (
      input  req_valid, req_write, req_size, req_seg, req_off, req_wdata, data,
      output req_ready, rsp_valid, rsp_rdata, busy, address, out, wren
   );

   modport master (
      output req_valid, req_write, req_size, req_seg, req_off, req_wdata, data,
      input  req_ready, rsp_valid, rsp_rdata, busy, address, out, wren
   );
endinterface

// File: rtl/core_bus_unit.sv
// Bus interface unit: turns one segment:offset request into little-endian byte cycles.
// state | meaning
// IDLE  | ready for a request; address/out hold their last values
// WRITE | one byte written per cycle, wren high
// READ  | one read address per cycle; data of the previous address captured
// DRAIN | no address; last read byte captured, response issued next cycle
module core_bus_unit #(
   parameter int ADDR_WIDTH  = 20,
   parameter int MAX_BYTES   = 4,
   parameter int OFFSET_WRAP = 1
) (
   input  logic          clock,
   input  logic          reset,
   core_bus_unit_if.slave bus
);
   localparam int SW = $clog2(MAX_BYTES);
   localparam int DW = 8 * MAX_BYTES;

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t                state, state_nxt;
   logic [SW-1:0]         idx, idx_nxt, idx_inc, cap_idx;
   logic [SW-1:0]         rem, rem_nxt, size_clamp;
   logic [15:0]           seg_q, seg_nxt, off_q, off_nxt;
   logic [DW-1:0]         wdata_q, wdata_nxt;
   logic [DW-1:0]         acc, acc_nxt, rdata_q, rdata_nxt;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
   logic [7:0]            out_q, out_nxt;
   logic                  wren_q, wren_nxt, rsp_q, rsp_nxt;
   logic                  accept;

   function automatic logic [ADDR_WIDTH-1:0] byte_addr(input logic [15:0] seg,
                                                       input logic [15:0] off,
                                                       input logic [SW-1:0] i);
      logic [15:0] off_w;
      logic [31:0] lin;
      off_w = off + 16'(i);
      if (OFFSET_WRAP != 0)
         lin = {12'h000, seg, 4'h0} + {16'h0000, off_w};
      else
         lin = {12'h000, seg, 4'h0} + {16'h0000, off} + 32'(i);
      return lin[ADDR_WIDTH-1:0];
   endfunction

   // Only a non-power-of-two MAX_BYTES can encode a size beyond the data bus.
   if ((1 << SW) > MAX_BYTES) begin : g_clamp
      assign size_clamp = (bus.req_size > SW'(MAX_BYTES - 1)) ? SW'(MAX_BYTES - 1) : bus.req_size;
   end else begin : g_noclamp
      assign size_clamp = bus.req_size;
   end

   assign accept  = bus.req_valid && (state == IDLE);
   assign idx_inc = idx + SW'(1);
   assign cap_idx = idx - SW'(1);

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      rem_nxt   = rem;
      seg_nxt   = seg_q;
      off_nxt   = off_q;
      wdata_nxt = wdata_q;
      acc_nxt   = acc;
      rdata_nxt = rdata_q;
      addr_nxt  = addr_q;
      out_nxt   = out_q;
      wren_nxt  = 1'b0;
      rsp_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               seg_nxt   = bus.req_seg;
               off_nxt   = bus.req_off;
               wdata_nxt = bus.req_wdata;
               acc_nxt   = '0;
               idx_nxt   = '0;
               rem_nxt   = size_clamp;
               addr_nxt  = byte_addr(bus.req_seg, bus.req_off, '0);
               if (bus.req_write) begin
                  state_nxt = WRITE;
                  out_nxt   = bus.req_wdata[7:0];
                  wren_nxt  = 1'b1;
               end else begin
                  state_nxt = READ;
               end
            end
         end
         WRITE: begin
            if (rem == '0) begin
               state_nxt = IDLE;
               rsp_nxt   = 1'b1;
            end else begin
               idx_nxt  = idx_inc;
               rem_nxt  = rem - SW'(1);
               addr_nxt = byte_addr(seg_q, off_q, idx_inc);
               out_nxt  = wdata_q[8*idx_inc +: 8];
               wren_nxt = 1'b1;
            end
         end
         READ: begin
            // Memory answers one cycle late, so this cycle's data belongs to the previous byte.
            if (idx != '0)
               acc_nxt[8*cap_idx +: 8] = bus.data;
            if (rem == '0) begin
               state_nxt = DRAIN;
            end else begin
               idx_nxt  = idx_inc;
               rem_nxt  = rem - SW'(1);
               addr_nxt = byte_addr(seg_q, off_q, idx_inc);
            end
         end
         DRAIN: begin
            acc_nxt[8*idx +: 8] = bus.data;
            rdata_nxt = acc_nxt;
            rsp_nxt   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         idx     <= '0;
         rem     <= '0;
         seg_q   <= '0;
         off_q   <= '0;
         wdata_q <= '0;
         acc     <= '0;
         rdata_q <= '0;
         addr_q  <= '0;
         out_q   <= '0;
         wren_q  <= 1'b0;
         rsp_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         rem     <= rem_nxt;
         seg_q   <= seg_nxt;
         off_q   <= off_nxt;
         wdata_q <= wdata_nxt;
         acc     <= acc_nxt;
         rdata_q <= rdata_nxt;
         addr_q  <= addr_nxt;
         out_q   <= out_nxt;
         wren_q  <= wren_nxt;
         rsp_q   <= rsp_nxt;
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.address   = addr_q;
   assign bus.out       = out_q;
   assign bus.wren      = wren_q;
   assign bus.rsp_valid = rsp_q;
   assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_core_bus_unit.sv
// Bench for core_bus_unit: offset-wrapping and free-running instances share the stimulus,
// each with its own memory image, checked against an address/byte-map reference model.
module tb_core_bus_unit;
   logic clock;
   logic reset;
   int   n_cmp;
   int   n_err;

   core_bus_unit_if #(.ADDR_WIDTH(20), .MAX_BYTES(4)) b1 ();
   core_bus_unit_if #(.ADDR_WIDTH(20), .MAX_BYTES(4)) b0 ();

   core_bus_unit #(.ADDR_WIDTH(20), .MAX_BYTES(4), .OFFSET_WRAP(1)) u_dut1 (
      .clock(clock), .reset(reset), .bus(b1));
   core_bus_unit #(.ADDR_WIDTH(20), .MAX_BYTES(4), .OFFSET_WRAP(0)) u_dut0 (
      .clock(clock), .reset(reset), .bus(b0));

   logic [7:0]  mem1 [0:1048575];
   logic [7:0]  mem0 [0:1048575];
   logic [7:0]  ref1 [int];
   logic [7:0]  ref0 [int];
   logic [31:0] last1, last0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous memories: data follows the address by one cycle.
   always @(posedge clock) begin
      b1.data <= mem1[b1.address];
      if (b1.wren) mem1[b1.address] = b1.out;
   end
   always @(posedge clock) begin
      b0.data <= mem0[b0.address];
      if (b0.wren) mem0[b0.address] = b0.out;
   end

   function automatic logic [7:0] pat(input int a);
      logic [31:0] t;
      t = (a * 73) ^ (a >> 7) ^ 32'h5A;
      return t[7:0];
   endfunction

   function automatic int ref_addr(input int seg, input int off, input int i, input bit wrap);
      int lin;
      if (wrap) lin = seg * 16 + ((off + i) % 65536);
      else      lin = seg * 16 + off + i;
      return lin % 1048576;
   endfunction

   function automatic logic [7:0] mbyte1(input int a);
      return ref1.exists(a) ? ref1[a] : pat(a);
   endfunction

   function automatic logic [7:0] mbyte0(input int a);
      return ref0.exists(a) ? ref0[a] : pat(a);
   endfunction

   task automatic preload(input int a, input logic [7:0] v);
      mem1[a] = v; mem0[a] = v; ref1[a] = v; ref0[a] = v;
   endtask

   task automatic set_req(input bit wr, input int n, input int seg, input int off, input logic [31:0] wd);
      b1.req_valid = 1'b1; b1.req_write = wr; b1.req_size = 2'(n - 1);
      b1.req_seg = 16'(seg); b1.req_off = 16'(off); b1.req_wdata = wd;
      b0.req_valid = 1'b1; b0.req_write = wr; b0.req_size = 2'(n - 1);
      b0.req_seg = 16'(seg); b0.req_off = 16'(off); b0.req_wdata = wd;
   endtask

   task automatic scramble_req();
      b1.req_valid = 1'b0; b1.req_write = 1'($urandom); b1.req_size = 2'($urandom);
      b1.req_seg = 16'($urandom); b1.req_off = 16'($urandom); b1.req_wdata = $urandom;
      b0.req_valid = 1'b0; b0.req_write = 1'($urandom); b0.req_size = 2'($urandom);
      b0.req_seg = 16'($urandom); b0.req_off = 16'($urandom); b0.req_wdata = $urandom;
   endtask

   // Starts in an idle (or response) cycle, ends in the response cycle of this request.
   task automatic run_txn(input bit wr, input int n, input int seg, input int off, input logic [31:0] wd);
      logic [31:0] exp1, exp0;
      int a1, a0;
      set_req(wr, n, seg, off, wd);
      n_cmp++;
      if (b1.req_ready !== 1'b1 || b0.req_ready !== 1'b1) begin
         n_err++; $display("FAIL req_ready_at_accept: got %b/%b want 1/1", b1.req_ready, b0.req_ready);
      end
      @(negedge clock);
      scramble_req();
      exp1 = '0; exp0 = '0;
      for (int k = 0; k < n; k++) begin
         a1 = ref_addr(seg, off, k, 1'b1);
         a0 = ref_addr(seg, off, k, 1'b0);
         n_cmp++;
         if (b1.address !== 20'(a1) || b1.wren !== wr || b1.busy !== 1'b1 || b1.rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bus_cycle_wrap1 byte %0d: addr=%h wren=%b busy=%b rsp=%b want addr=%h wren=%b busy=1 rsp=0",
                     k, b1.address, b1.wren, b1.busy, b1.rsp_valid, 20'(a1), wr);
         end
         n_cmp++;
         if (b0.address !== 20'(a0) || b0.wren !== wr || b0.busy !== 1'b1 || b0.rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bus_cycle_wrap0 byte %0d: addr=%h wren=%b busy=%b rsp=%b want addr=%h wren=%b busy=1 rsp=0",
                     k, b0.address, b0.wren, b0.busy, b0.rsp_valid, 20'(a0), wr);
         end
         if (wr) begin
            n_cmp++;
            if (b1.out !== wd[8*k +: 8] || b0.out !== wd[8*k +: 8]) begin
               n_err++; $display("FAIL write_byte %0d: out=%h/%h want %h", k, b1.out, b0.out, wd[8*k +: 8]);
            end
            ref1[a1] = wd[8*k +: 8];
            ref0[a0] = wd[8*k +: 8];
         end else begin
            exp1[8*k +: 8] = mbyte1(a1);
            exp0[8*k +: 8] = mbyte0(a0);
         end
         @(negedge clock);
      end
      if (!wr) begin
         n_cmp++;
         if (b1.busy !== 1'b1 || b0.busy !== 1'b1 || b1.rsp_valid !== 1'b0 || b0.rsp_valid !== 1'b0 ||
             b1.wren !== 1'b0 || b0.wren !== 1'b0) begin
            n_err++; $display("FAIL drain_cycle: busy=%b/%b rsp=%b/%b wren=%b/%b want busy=1 rsp=0 wren=0",
                              b1.busy, b0.busy, b1.rsp_valid, b0.rsp_valid, b1.wren, b0.wren);
         end
         @(negedge clock);
         last1 = exp1; last0 = exp0;
      end
      n_cmp++;
      if (b1.rsp_valid !== 1'b1 || b0.rsp_valid !== 1'b1 || b1.wren !== 1'b0 || b0.wren !== 1'b0 ||
          b1.busy !== 1'b0 || b0.busy !== 1'b0) begin
         n_err++; $display("FAIL response_cycle: rsp=%b/%b wren=%b/%b busy=%b/%b want rsp=1 wren=0 busy=0",
                           b1.rsp_valid, b0.rsp_valid, b1.wren, b0.wren, b1.busy, b0.busy);
      end
      n_cmp++;
      if (b1.rsp_rdata !== last1 || b0.rsp_rdata !== last0) begin
         n_err++; $display("FAIL rsp_rdata: got %h/%h want %h/%h", b1.rsp_rdata, b0.rsp_rdata, last1, last0);
      end
   endtask

   task automatic idle(input int c);
      for (int i = 0; i < c; i++) begin
         @(negedge clock);
         n_cmp++;
         if (b1.rsp_valid !== 1'b0 || b0.rsp_valid !== 1'b0 || b1.wren !== 1'b0 || b0.wren !== 1'b0 ||
             b1.busy !== 1'b0 || b0.busy !== 1'b0 || b1.req_ready !== 1'b1 || b0.req_ready !== 1'b1) begin
            n_err++; $display("FAIL idle_cycle: rsp=%b/%b wren=%b/%b busy=%b/%b ready=%b/%b want 0/0 0/0 0/0 1/1",
                              b1.rsp_valid, b0.rsp_valid, b1.wren, b0.wren, b1.busy, b0.busy,
                              b1.req_ready, b0.req_ready);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      for (int r = 0; r < 2; r++) begin
         n_cmp++;
         if (b1.address !== 20'h00000 || b1.wren !== 1'b0 || b1.out !== 8'h00 || b1.req_ready !== 1'b1 ||
             b1.rsp_valid !== 1'b0 || b1.busy !== 1'b0 || b1.rsp_rdata !== 32'h0 || b0.address !== 20'h00000) begin
            n_err++; $display("FAIL reset_state %0d: addr=%h wren=%b out=%h ready=%b rsp=%b busy=%b rdata=%h want 0 0 0 1 0 0 0",
                              r, b1.address, b1.wren, b1.out, b1.req_ready, b1.rsp_valid, b1.busy, b1.rsp_rdata);
         end
         reset = 1'b0;
         @(negedge clock);
      end
      last1 = '0; last0 = '0;
   endtask

   task automatic test_write_wrap();
      run_txn(1'b1, 2, 'h1234, 'hFFFF, 32'h0000BEEF);
      n_cmp++;
      if (mem1[20'h2233F] !== 8'hEF || mem1[20'h12340] !== 8'hBE || mem0[20'h22340] !== 8'hBE) begin
         n_err++; $display("FAIL write_wrap_mem: got %h %h %h want ef be be",
                           mem1[20'h2233F], mem1[20'h12340], mem0[20'h22340]);
      end
      idle(1);
   endtask

   task automatic test_read_a20();
      preload('hFFFF0, 8'h11); preload('hFFFF1, 8'h22);
      preload('hFFFF2, 8'h33); preload('hFFFF3, 8'h44);
      preload('h00000, 8'hA5);
      run_txn(1'b0, 4, 'hF000, 'hFFF0, 32'h0);
      n_cmp++;
      if (b1.rsp_rdata !== 32'h44332211 || b0.rsp_rdata !== 32'h44332211) begin
         n_err++; $display("FAIL read4_word: got %h/%h want 44332211", b1.rsp_rdata, b0.rsp_rdata);
      end
      run_txn(1'b0, 1, 'hFFFF, 'h0010, 32'h0);
      n_cmp++;
      if (b1.rsp_rdata !== 32'h000000A5 || b0.rsp_rdata !== 32'h000000A5) begin
         n_err++; $display("FAIL read1_a20: got %h/%h want 000000a5", b1.rsp_rdata, b0.rsp_rdata);
      end
      idle(2);
   endtask

   task automatic test_back_to_back();
      run_txn(1'b0, 3, 'h2000, 'hFFFE, 32'h0);
      run_txn(1'b1, 4, 'h3000, 'h0100, 32'hCAFEF00D);
      run_txn(1'b0, 4, 'h3000, 'h0100, 32'h0);
      n_cmp++;
      if (b1.rsp_rdata !== 32'hCAFEF00D || b0.rsp_rdata !== 32'hCAFEF00D) begin
         n_err++; $display("FAIL readback_word: got %h/%h want cafef00d", b1.rsp_rdata, b0.rsp_rdata);
      end
      idle(1);
   endtask

   task automatic test_reset_mid_write();
      int seg, off;
      logic [31:0] wd;
      seg = 'h4321; off = 'hFFFE; wd = 32'h89ABCDEF;
      set_req(1'b1, 4, seg, off, wd);
      @(negedge clock);
      scramble_req();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      n_cmp++;
      if (b1.wren !== 1'b0 || b0.wren !== 1'b0 || b1.busy !== 1'b0 || b0.busy !== 1'b0 ||
          b1.rsp_valid !== 1'b0 || b0.rsp_valid !== 1'b0 || b1.address !== 20'h0) begin
         n_err++; $display("FAIL mid_reset_state: wren=%b/%b busy=%b/%b rsp=%b/%b addr=%h want 0 0 0 addr 0",
                           b1.wren, b0.wren, b1.busy, b0.busy, b1.rsp_valid, b0.rsp_valid, b1.address);
      end
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         ref1[ref_addr(seg, off, k, 1'b1)] = wd[8*k +: 8];
         ref0[ref_addr(seg, off, k, 1'b0)] = wd[8*k +: 8];
      end
      last1 = '0; last0 = '0;
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (mem1[ref_addr(seg, off, k, 1'b1)] !== mbyte1(ref_addr(seg, off, k, 1'b1)) ||
             mem0[ref_addr(seg, off, k, 1'b0)] !== mbyte0(ref_addr(seg, off, k, 1'b0))) begin
            n_err++; $display("FAIL mid_reset_mem byte %0d: got %h/%h want %h/%h", k,
                              mem1[ref_addr(seg, off, k, 1'b1)], mem0[ref_addr(seg, off, k, 1'b0)],
                              mbyte1(ref_addr(seg, off, k, 1'b1)), mbyte0(ref_addr(seg, off, k, 1'b0)));
         end
      end
      idle(3);
   endtask

   task automatic test_random();
      bit wr;
      int n, seg, off;
      for (int t = 0; t < 60; t++) begin
         wr  = 1'($urandom);
         n   = 1 + int'($urandom_range(0, 3));
         seg = ($urandom_range(0, 3) == 0) ? 'hFFF0 + int'($urandom_range(0, 15)) : int'($urandom_range(0, 65535));
         off = ($urandom_range(0, 2) == 0) ? 'hFFFC + int'($urandom_range(0, 3)) : int'($urandom_range(0, 65535));
         if ($urandom_range(0, 3) == 0) seg = 'h0100;
         run_txn(wr, n, seg, off, $urandom);
         idle(int'($urandom_range(0, 2)));
      end
      idle(1);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_size = '0;
      b1.req_seg = '0; b1.req_off = '0; b1.req_wdata = '0;
      b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_size = '0;
      b0.req_seg = '0; b0.req_off = '0; b0.req_wdata = '0;
      for (int i = 0; i < 1048576; i++) begin
         mem1[i] = pat(i);
         mem0[i] = pat(i);
      end
      test_reset();
      test_write_wrap();
      test_read_a20();
      test_back_to_back();
      test_reset_mid_write();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, summary not reached");
      $fatal(1, "watchdog");
   end
endmodule
